// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU for the execute stage of the RSA pipeline CPU.
//
// ADD/SUB/AND/OR/XOR finish on the accept edge.
// MUL/MULH use an unsigned shift-add multiplier that takes N clocks.
// The modulo op uses an unsigned restoring divider that also takes N clocks.
// Results and flags are registered and hold until the next completion.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   start_i    request, accepted when busy_o is low
//   a_i, b_i   operands (b_i is the divisor for MOD)
//   opcode_i   000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 MOD,
//              110 XOR, 111 MULH
//   busy_o     multi-cycle operation in progress
//   valid_o    one-cycle pulse when result_o/ALUFlags_o update
//   result_o   registered result
//   ALUFlags_o registered flags {neg, zero, carry, overflow}
module alu_seq #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [2:0]   opcode_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic [N-1:0] result_o,
  output logic [3:0]   ALUFlags_o
);

  localparam int CW = $clog2(N);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_MOD  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MULH = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t         state, next_state;
  logic [CW-1:0]  count;
  logic           last_iter;

  logic [N-1:0]   mul_a;
  logic [N-1:0]   mul_b;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_next;
  logic [N:0]     partial;
  logic           want_high;

  logic [N-1:0]   div_b;
  logic [N-1:0]   dividend;
  logic [N-1:0]   rem;
  logic [N-1:0]   rem_next;
  logic [N:0]     trial;

  logic [N-1:0]   b_eff;
  logic [N:0]     sum;
  logic [N-1:0]   alu_res;
  logic [3:0]     alu_flags;
  logic [N-1:0]   mul_res;
  logic [3:0]     mul_flags;
  logic [3:0]     div_flags;

  assign busy_o    = (state != IDLE);
  assign last_iter = (count == CW'(N - 1));

  // Single-cycle datapath. SUB reuses the adder as a + ~b + 1, so the carry
  // out reads as "no borrow" and the overflow test is shared with ADD.
  always_comb begin
    b_eff     = (opcode_i == OP_SUB) ? ~b_i : b_i;
    sum       = {1'b0, a_i} + {1'b0, b_eff} + {{N{1'b0}}, (opcode_i == OP_SUB)};
    alu_res   = '0;
    alu_flags = '0;
    case (opcode_i)
      OP_ADD, OP_SUB: begin
        alu_res      = sum[N-1:0];
        alu_flags[1] = sum[N];
        alu_flags[0] = (a_i[N-1] == b_eff[N-1]) && (sum[N-1] != a_i[N-1]);
      end
      OP_AND:  alu_res = a_i & b_i;
      OP_OR:   alu_res = a_i | b_i;
      OP_XOR:  alu_res = a_i ^ b_i;
      default: alu_res = '0;
    endcase
    alu_flags[3] = alu_res[N-1];
    alu_flags[2] = (alu_res == '0);
  end

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  // After N steps acc holds the full 2N-bit product.
  always_comb begin
    partial   = {1'b0, acc[2*N-1:N]} + (mul_b[0] ? {1'b0, mul_a} : '0);
    acc_next  = {partial, acc[N-1:1]};
    mul_res   = want_high ? acc_next[2*N-1:N] : acc_next[N-1:0];
    mul_flags = '0;
    mul_flags[3] = mul_res[N-1];
    mul_flags[2] = (mul_res == '0);
    mul_flags[0] = !want_high && (acc_next[2*N-1:N] != '0);
  end

  // One restoring-division step, dividend MSB first. The remainder is kept
  // below the divisor, so the subtraction fits in N bits. With a zero divisor
  // every trial "succeeds" and the remainder simply shifts in the dividend,
  // which leaves a in the remainder after N steps.
  always_comb begin
    trial     = {rem, dividend[N-1]};
    rem_next  = (trial >= {1'b0, div_b}) ? (trial[N-1:0] - div_b) : trial[N-1:0];
    div_flags = '0;
    div_flags[3] = rem_next[N-1];
    div_flags[2] = (rem_next == '0);
    div_flags[0] = (div_b == '0);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic: MUL/MULH and MOD leave IDLE on accept and come back on
  // the final iteration edge.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (opcode_i == OP_MUL || opcode_i == OP_MULH) next_state = MUL;
          else if (opcode_i == OP_MOD)                  next_state = DIV;
        end
      end
      MUL:     if (last_iter) next_state = IDLE;
      DIV:     if (last_iter) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers: operand latching, iteration, and result/flag update.
  // valid_o defaults low so it only pulses on completion edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count      <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      acc        <= '0;
      want_high  <= 1'b0;
      div_b      <= '0;
      dividend   <= '0;
      rem        <= '0;
      valid_o    <= 1'b0;
      result_o   <= '0;
      ALUFlags_o <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (opcode_i == OP_MUL || opcode_i == OP_MULH) begin
              mul_a     <= a_i;
              mul_b     <= b_i;
              acc       <= '0;
              want_high <= (opcode_i == OP_MULH);
              count     <= '0;
            end else if (opcode_i == OP_MOD) begin
              div_b    <= b_i;
              dividend <= a_i;
              rem      <= '0;
              count    <= '0;
            end else begin
              result_o   <= alu_res;
              ALUFlags_o <= alu_flags;
              valid_o    <= 1'b1;
            end
          end
        end
        MUL: begin
          acc   <= acc_next;
          mul_b <= mul_b >> 1;
          count <= count + CW'(1);
          if (last_iter) begin
            count      <= '0;
            result_o   <= mul_res;
            ALUFlags_o <= mul_flags;
            valid_o    <= 1'b1;
          end
        end
        DIV: begin
          rem      <= rem_next;
          dividend <= dividend << 1;
          count    <= count + CW'(1);
          if (last_iter) begin
            count      <= '0;
            result_o   <= rem_next;
            ALUFlags_o <= div_flags;
            valid_o    <= 1'b1;
          end
        end
        default: count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq with N=8.
// Expected results are computed from plain integer arithmetic when an
// operation is driven, queued with the edge they are due on, and compared
// when valid_o is seen. busy_o and the held result/flags are checked every
// cycle against the bench's own timing model.
module tb_alu_seq;

  localparam int N = 8;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_MOD  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MULH = 3'b111;

  typedef struct {
    logic [N-1:0] res;
    logic [3:0]   flags;
    int           due;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   opcode;
  logic         busy;
  logic         valid;
  logic [N-1:0] result;
  logic [3:0]   flags;

  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   free_edge = 0;
  int   busy_from = 1;
  int   busy_to = 0;
  logic [N-1:0] held_res = '0;
  logic [3:0]   held_flags = '0;
  exp_t sb[$];

  alu_seq #(.N(N)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .a_i(a),
    .b_i(b),
    .opcode_i(opcode),
    .busy_o(busy),
    .valid_o(valid),
    .result_o(result),
    .ALUFlags_o(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               tag, observed, expected, cycle);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [N-1:0] x,
                                 input logic [N-1:0] y);
    exp_t e;
    int   xi, yi, full;
    logic c, v;
    xi = int'(x);
    yi = int'(y);
    c = 1'b0;
    v = 1'b0;
    e.due = 0;
    case (op)
      OP_ADD: begin
        full = xi + yi;
        e.res = full[N-1:0];
        c = (full >= (1 << N));
        v = (x[N-1] == y[N-1]) && (e.res[N-1] != x[N-1]);
      end
      OP_SUB: begin
        full = xi - yi;
        e.res = full[N-1:0];
        c = (xi >= yi);
        v = (x[N-1] != y[N-1]) && (e.res[N-1] != x[N-1]);
      end
      OP_AND: e.res = x & y;
      OP_OR:  e.res = x | y;
      OP_XOR: e.res = x ^ y;
      OP_MUL: begin
        full = xi * yi;
        e.res = full[N-1:0];
        v = (full >= (1 << N));
      end
      OP_MULH: begin
        full = xi * yi;
        e.res = full[2*N-1:N];
      end
      default: begin
        full = (yi == 0) ? xi : (xi % yi);
        e.res = full[N-1:0];
        v = (yi == 0);
      end
    endcase
    e.flags = {e.res[N-1], (e.res == '0), c, v};
    return e;
  endfunction

  // Drive one request for exactly one edge (start stays high afterwards so
  // consecutive calls issue back-to-back). The bench decides on its own
  // whether the DUT should accept it.
  task automatic applyStimulus(input logic [2:0] op, input logic [N-1:0] x,
                               input logic [N-1:0] y);
    exp_t e;
    int   edge_no;
    @(negedge clk);
    start  = 1'b1;
    opcode = op;
    a      = x;
    b      = y;
    edge_no = cycle + 1;
    if (edge_no >= free_edge) begin
      e = model(op, x, y);
      if (op == OP_MUL || op == OP_MULH || op == OP_MOD) begin
        e.due     = edge_no + N;
        busy_from = edge_no;
        busy_to   = edge_no + N - 1;
        free_edge = edge_no + N + 1;
      end else begin
        e.due     = edge_no;
        free_edge = edge_no + 1;
      end
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      a = $urandom();
      b = $urandom();
      @(posedge clk);
    end
  endtask

  task automatic modelReset();
    sb.delete();
    busy_from  = 1;
    busy_to    = 0;
    free_edge  = 0;
    held_res   = '0;
    held_flags = '0;
  endtask

  // Monitor: sample just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    checkOutput("busy", {31'd0, busy}, {31'd0, (cycle >= busy_from && cycle <= busy_to)});
    if (valid) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_valid", {31'd0, valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("latency", cycle, e.due);
        held_res   = e.res;
        held_flags = e.flags;
      end
    end else if (sb.size() > 0 && sb[0].due <= cycle) begin
      checkOutput("missing_valid", {31'd0, valid}, 32'd1);
      e = sb.pop_front();
      held_res   = e.res;
      held_flags = e.flags;
    end
    checkOutput("result", {24'd0, result}, {24'd0, held_res});
    checkOutput("flags", {28'd0, flags}, {28'd0, held_flags});
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    opcode = OP_ADD;
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_valid", {31'd0, valid}, 32'd0);
    checkOutput("reset_result", {24'd0, result}, 32'd0);
    checkOutput("reset_flags", {28'd0, flags}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idleCycles(2);

    // ADD overflow into the sign bit.
    applyStimulus(OP_ADD, 8'h7F, 8'h01);
    idleCycles(1);
    // SUB to zero, then back-to-back SUB with borrow.
    applyStimulus(OP_SUB, 8'h05, 8'h05);
    applyStimulus(OP_SUB, 8'h00, 8'h01);
    applyStimulus(OP_AND, 8'hF0, 8'h3C);
    applyStimulus(OP_OR,  8'h00, 8'h00);
    applyStimulus(OP_XOR, 8'hAA, 8'h55);
    idleCycles(1);

    // MUL low half overflows to zero, then MULH of the same operands.
    applyStimulus(OP_MUL, 8'h10, 8'h20);
    idleCycles(N);
    applyStimulus(OP_MULH, 8'h10, 8'h20);
    idleCycles(N + 1);

    // Modulo, then modulo by zero.
    applyStimulus(OP_MOD, 8'd200, 8'd7);
    idleCycles(N + 1);
    applyStimulus(OP_MOD, 8'd200, 8'd0);
    idleCycles(N + 1);

    // Start while busy is ignored; ADD issued in the valid cycle completes.
    applyStimulus(OP_MUL, 8'd3, 8'd5);
    idleCycles(1);
    applyStimulus(OP_ADD, 8'd1, 8'd1);
    idleCycles(N - 2);
    applyStimulus(OP_ADD, 8'd2, 8'd3);
    idleCycles(2);

    // Reset in the middle of a MOD.
    applyStimulus(OP_MOD, 8'd100, 8'd9);
    idleCycles(3);
    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_valid", {31'd0, valid}, 32'd0);
    checkOutput("midreset_result", {24'd0, result}, 32'd0);
    checkOutput("midreset_flags", {28'd0, flags}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idleCycles(N + 2);
    applyStimulus(OP_ADD, 8'h40, 8'h02);
    idleCycles(2);

    // Random mix with random spacing, including issues while busy.
    for (int i = 0; i < 30; i++) begin
      logic [2:0]   rop;
      logic [N-1:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = N'($urandom());
      rb  = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom());
      applyStimulus(rop, ra, rb);
      idleCycles($urandom_range(0, N + 1));
    end

    idleCycles(N + 2);
    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU for the RSA pipeline CPU execute stage. It extends the combinational N-bit ALU with three things:
- registered outputs;
- a start/valid handshake;
- iterative unsigned multiply (low/high half) and modulo units, which RSA modular arithmetic needs.

Single-cycle ops complete in one clock. MUL/MULH/MOD take N clocks, during which the ALU reports busy to the pipeline stall logic.

## Interface
- N, 32, operand/result width in bits (N ≥ 4).
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  request; accepted on an edge where start_i=1 and busy_o=0.
- a_i  in  N  operand A, sampled at accept.
- b_i  in  N  operand B / divisor, sampled at accept.
- opcode_i  in  3  operation, sampled at accept: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL (low N bits), 101 MOD (a mod b), 110 XOR, 111 MULH (high N bits).
- busy_o  out  1  multi-cycle operation in progress.
- valid_o  out  1  one-cycle pulse: result_o/ALUFlags_o updated this cycle.
- result_o  out  N  registered result; holds until the next completion.
- ALUFlags_o  out  4  registered flags {N,Z,C,V} = bits [3:0] = {neg, zero, carry, overflow}.

## Operation
- **FSM states:** IDLE, MUL, DIV.
- **Accept of ADD/SUB/AND/OR/XOR:** compute combinationally on a_i/b_i and register result/flags; state stays IDLE.
- **Accept of MUL/MULH:** enter MUL. Latch A, B and the op, and clear the 2N-bit accumulator.
  - Shift-add, one multiplier bit per cycle, N iterations via a counter.
- **Accept of MOD:** enter DIV. Latch A, B and clear the N-bit remainder.
  - Restoring division, one dividend bit per cycle (MSB first), N iterations.
- **Completion:** the final iteration's edge registers result and flags, pulses valid_o and returns to IDLE.
- **Unsigned arithmetic:** all of MUL/MULH/MOD is unsigned.
- **Flags:**
  - N = result[N-1] for all ops.
  - Z = (result == 0) for all ops.
  - ADD: C = carry out of bit N-1; V = signed overflow.
  - SUB: computed as a + ~b + 1. C = carry out (1 = no borrow); V = signed overflow.
  - AND, OR, XOR, MULH: C = 0, V = 0.
  - MUL: C = 0; V = 1 iff the high N bits of the product are nonzero.
  - MOD: C = 0; V = 1 iff b = 0.
- **MOD with b = 0:** result = a and V = 1. It still takes N cycles, so latency is uniform.
- **start_i with busy_o=1:** ignored, no queueing. The operands on the bus at that time have no effect.
- **start_i in the cycle valid_o is high:** accepted, since busy_o is already 0 then. This allows back-to-back issue.

## Timing
- **Reset (rst_ni=0, immediate, asynchronous):**
  - state = IDLE, counter = 0, busy_o = 0, valid_o = 0, result_o = 0, ALUFlags_o = 0.
  - Any in-flight MUL/DIV is aborted with no valid_o.
- **Accept edge E0:**
  - Single-cycle op: result/flags/valid_o update at E0. Latency 1; one op accepted per cycle.
  - Multi-cycle op: busy_o = 1 after E0 through E(N-1). At E(N), result and flags update, valid_o = 1 and busy_o = 0.
  - A multi-cycle op therefore completes N clocks after accept, with valid_o high for exactly one cycle.
- **valid_o:** deasserts on the edge after its pulse unless another completion occurs at that edge.
- **Stability:** result_o and ALUFlags_o change only on completion edges or reset.

## Test plan
All scenarios use N=8.
- **Reset, then ADD:**
  - Release reset; all outputs are 0.
  - ADD 0x7F + 0x01 → at E0: result 0x80, flags N=1, Z=0, C=0, V=1, valid_o pulse.
- **SUB zero, then SUB borrow:**
  - SUB 0x05 − 0x05 → result 0x00, N=0, Z=1, C=1, V=0.
  - Back-to-back SUB 0x00 − 0x01 → result 0xFF, N=1, C=0.
- **MUL/MULH:**
  - MUL 0x10 × 0x20 → busy_o high 8 cycles. At E8: result 0x00, Z=1, V=1.
  - Then MULH with the same operands → result 0x02, V=0.
  - Check there is exactly one valid_o pulse per op.
- **MOD and divide-by-zero:**
  - MOD 200 mod 7 → result 0x04 at E8.
  - MOD 200 mod 0 → result 0xC8, V=1, same 8-cycle latency.
- **start while busy:**
  - Accept MUL 3 × 5, then pulse start_i with ADD 1 + 1 at E2 while busy.
  - Only the MUL completes (result 0x0F at E8). No ADD result appears.
  - An ADD issued in the valid_o cycle completes at the next edge.
- **Reset mid-operation:**
  - Accept MOD 100 mod 9, then assert rst_ni=0 at cycle 4.
  - busy_o, valid_o, result_o and flags go to 0 immediately. No valid_o follows after reset release.
  - A new ADD then works normally.
